// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch queue.
package fetch_pkg;
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1,
        STOP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] INST_NOP         = 32'h0;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          ENTRY_W          = 64;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch bus: instruction-memory read port, redirect request and decode handshake.
interface inst_fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;

    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect,
        input  redirect_pc,
        output if_valid,
        input  if_ready,
        output if_inst,
        output if_pc
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect,
        output redirect_pc,
        input  if_valid,
        output if_ready,
        input  if_inst,
        input  if_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Generic synchronous FIFO with flush; head is read combinationally from storage.
// Latency: a push is visible at head the cycle after. Backpressure: push ignored when full, pop when empty.
// Flush dominates push and pop in the same cycle.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // Storage needs no reset: count gates everything read from it.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch unit: owns fetch_pc, prefetches {pc, inst} into a queue and serves decode via if_valid/if_ready.
// Latency: fetch to if_valid 1 cycle; redirect target valid 2 cycles after the pulse.
// Backpressure: if_ready low fills the queue, then fetch holds; FETCH_PERF_CNT_EN adds perf counters.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          INST_WORDS  = 60,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    inst_fetch_unit_if.master fetch_bus,
    output logic              fetch_fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);
    localparam logic [29:0] WORD_LIMIT = 30'(INST_WORDS);

    fetch_state_t       state;
    fetch_state_t       state_nxt;
    logic [31:0]        fetch_pc;
    logic               push;
    logic               pop;
    logic               q_empty;
    logic               q_full;
    logic               in_range;
    fetch_entry_t       push_entry;
    fetch_entry_t       head_entry;
    logic [ENTRY_W-1:0] head_raw;

    assign in_range   = (fetch_pc[31:2] < WORD_LIMIT);
    assign push_entry = '{pc: fetch_pc, inst: fetch_bus.imem_data};
    assign head_entry = fetch_entry_t'(head_raw);

    assign fetch_bus.imem_addr = fetch_pc;
    assign fetch_bus.if_valid  = !q_empty;
    assign fetch_bus.if_inst   = q_empty ? INST_NOP : head_entry.inst;
    assign fetch_bus.if_pc     = q_empty ? 32'h0 : head_entry.pc;
    assign fetch_fault         = (state == STOP);

    // A redirect cancels any pop, even with if_ready high.
    assign pop = !q_empty && fetch_bus.if_ready && !fetch_bus.redirect;

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        if (fetch_bus.redirect) begin
            state_nxt = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (q_full) begin
                        if (!pop) state_nxt = HOLD;
                    end else if (!in_range) begin
                        state_nxt = STOP;
                    end else begin
                        push = 1'b1;
                    end
                end
                HOLD:    if (pop) state_nxt = RUN;
                STOP:    state_nxt = STOP;
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (fetch_bus.redirect) fetch_pc <= word_align(fetch_bus.redirect_pc);
            else if (push)          fetch_pc <= fetch_pc + 32'd4;
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (fetch_bus.redirect),
        .din   (push_entry),
        .head  (head_raw),
        .empty (q_empty),
        .full  (q_full)
    );

`ifdef FETCH_PERF_CNT_EN
    // Counters saturate and survive redirects; only reset clears them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (push && perf_fetched != '1) perf_fetched <= perf_fetched + 32'd1;
            if ((state == HOLD || state == STOP) && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif
endmodule
